// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button input stage.
// State encoding is fixed so waveforms and debug probes stay readable across revisions.
package btn_pkg;

  typedef enum logic [1:0] {
    StRel   = 2'd0,
    StWaitP = 2'd1,
    StHeld  = 2'd2,
    StWaitR = 2'd3
  } btn_state_e;

  // Pin level seen when nobody touches the button.
  function automatic logic idle_pin_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser for asynchronous board inputs.
// Resets synchronously to RST_VAL so the downstream logic sees a known idle level.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] stages_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      stages_q <= {stages_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: synchronise, debounce, and emit a clean level plus
// single-cycle press/release pulses for the LED counter's step input.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  localparam int unsigned CntW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic IdleLevel        = idle_pin_level(ACTIVE_LOW);

  logic       pin_sync;
  logic       s;
  logic       done;

  btn_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            press_q;
  logic            release_q;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (IdleLevel)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (pin_sync)
  );

  // Normalise polarity so 1 always means pressed from here on.
  assign s    = pin_sync ^ ACTIVE_LOW;
  assign done = (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRel;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;

      // Count only while the input disagrees with the accepted level; any
      // agreement (a bounce) restarts the window. Cleared at the accept point.
      if (s == level_q || done) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      unique case (state_q)
        StRel: begin
          if (s) state_q <= StWaitP;
        end
        StWaitP: begin
          if (!s) begin
            state_q <= StRel;
          end else if (done) begin
            state_q <= StHeld;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end
        end
        StHeld: begin
          if (!s) state_q <= StWaitR;
        end
        StWaitR: begin
          if (s) begin
            state_q <= StHeld;
          end else if (done) begin
            state_q   <= StRel;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end
        end
        default: state_q <= StRel;
      endcase
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

  a_pulse_excl: assert property (@(posedge clk) disable iff (rst)
    !(press_q && release_q));
  a_no_back_to_back: assert property (@(posedge clk) disable iff (rst)
    (press_q || release_q) |=> !(press_q || release_q));

endmodule

// File: tb/tb_btn_debounce.sv
// Directed and randomised bench for btn_debounce against a window-based
// reference: a level change is accepted once the last D synchronised samples all disagree.
module tb_btn_debounce;

  localparam int unsigned D = 4;
  localparam int unsigned S = 2;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_pulse = -1000;
  int press_seen = 0;
  int rel_seen   = 0;

  // Reference model state
  logic pq[$];
  logic win[$];
  logic exp_level, exp_press, exp_rel;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // pq holds the pressed-sense samples of the last S edges; the oldest one is
  // what the debouncer sees at this edge.
  task automatic model_edge(input logic pin, input logic r);
    logic s;
    bit all_diff;
    s = pq[0];
    void'(pq.pop_front());
    pq.push_back(r ? 1'b0 : ~pin);
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    if (r) begin
      win.delete();
      exp_level = 1'b0;
    end else begin
      win.push_back(s);
      if (win.size() > D) void'(win.pop_front());
      all_diff = (win.size() == D);
      foreach (win[i]) if (win[i] == exp_level) all_diff = 1'b0;
      if (all_diff) begin
        exp_level = ~exp_level;
        exp_press = exp_level;
        exp_rel   = ~exp_level;
        win.delete();
      end
    end
  endtask

  task automatic step(input logic pin, input logic r);
    btn_in = pin;
    rst    = r;
    @(posedge clk);
    model_edge(pin, r);
    cyc++;
    #1;
    check("btn_level", btn_level, exp_level);
    check("press_pulse", press_pulse, exp_press);
    check("release_pulse", release_pulse, exp_rel);
    check("pulse_excl", press_pulse & release_pulse, 1'b0);
    if (press_pulse === 1'b1 || release_pulse === 1'b1) begin
      check("pulse_gap", (cyc - last_pulse) >= int'(D), 1'b1);
      last_pulse = cyc;
    end
    if (press_pulse === 1'b1) press_seen++;
    if (release_pulse === 1'b1) rel_seen++;
  endtask

  task automatic hold(input logic pin, input int n);
    for (int i = 0; i < n; i++) step(pin, 1'b0);
  endtask

  initial begin
    int p0, r0;
    logic pin;
    int run;
    pq = {1'b0, 1'b0};
    exp_level = 1'b0;
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    rst    = 1'b1;
    btn_in = 1'b0;

    // 1: reset with button held, press after full latency
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    p0 = press_seen;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0);
      if (i == 5) check("rst_hold_no_early_press", press_pulse, 1'b0);
      if (i == 6) check("rst_hold_press_edge6", press_pulse, 1'b1);
    end
    check_int("rst_hold_press_count", press_seen - p0, 1);
    hold(1'b1, 8);

    // 2: clean press
    p0 = press_seen; r0 = rel_seen;
    hold(1'b0, 8);
    check_int("clean_press_count", press_seen - p0, 1);
    check_int("clean_press_no_release", rel_seen - r0, 0);
    check("clean_press_level", btn_level, 1'b1);
    hold(1'b1, 8);

    // 3: short glitch low
    p0 = press_seen;
    hold(1'b0, 3);
    hold(1'b1, 8);
    check_int("glitch_no_press", press_seen - p0, 0);
    check("glitch_level", btn_level, 1'b0);

    // 4: bounce then settle pressed
    p0 = press_seen;
    hold(1'b0, 2); hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1);
    hold(1'b0, 8);
    check_int("bounce_single_press", press_seen - p0, 1);

    // 5: release from held, then high glitch while held
    r0 = rel_seen;
    hold(1'b1, 8);
    check_int("release_count", rel_seen - r0, 1);
    check("release_level", btn_level, 1'b0);
    hold(1'b0, 8);
    r0 = rel_seen;
    hold(1'b1, 2);
    hold(1'b0, 6);
    check_int("held_glitch_no_release", rel_seen - r0, 0);
    check("held_glitch_level", btn_level, 1'b1);

    // 6: reset while held
    r0 = rel_seen; p0 = press_seen;
    step(1'b0, 1'b1);
    check("rst_held_level", btn_level, 1'b0);
    hold(1'b0, 8);
    check_int("rst_held_no_release", rel_seen - r0, 0);
    check_int("rst_held_repress", press_seen - p0, 1);

    // 7: random bouncing with occasional resets
    for (int k = 0; k < 120; k++) begin
      pin = 1'($urandom_range(1));
      run = $urandom_range(7, 1);
      if ($urandom_range(31) == 0) step(pin, 1'b1);
      hold(pin, run);
    end
    hold(1'b1, 10);
    check("final_level", btn_level, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
